// File: rtl/matmul_sequencer.sv
// ============================================================================
// Module   : matmul_sequencer
// Purpose  : Sequences one integer matrix multiply C = A x B. The block reads
//            the dimensions from word 0 of the input and weight SRAMs. It then
//            walks the operand addresses for each dot product in row-major
//            order and drives the MAC datapath controls. Once the MAC pipeline
//            has drained, it writes each C element to the result SRAM.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   1       rising-edge clock
//   reset_n         in   1       asynchronous active-low reset
//   dut_valid       in   1       job request (sampled only while idle)
//   dut_ready       out  1       high exactly while idle
//   input_rd_addr   out  ADDR_W  matrix A read address
//   input_rd_data   in   DATA_W  matrix A read data (one cycle after address)
//   weight_rd_addr  out  ADDR_W  matrix B read address
//   weight_rd_data  in   DATA_W  matrix B read data (one cycle after address)
//   mac_clear       out  1       restart accumulation with current operands
//   mac_en          out  1       operands on the read-data buses are valid
//   mac_last        out  1       final operand pair of the dot product
//   mac_result      in   DATA_W  accumulator output
//   result_wr_en    out  1       result SRAM write strobe
//   result_wr_addr  out  ADDR_W  result SRAM write address
//   result_wr_data  out  DATA_W  result SRAM write data
// Dimension word layout: input[0] = {M, K}, weight[0] = {unused, N}.
// DATA_W must be at least 32 so that the dimension fields exist.
// ============================================================================
`default_nettype none

module matmul_sequencer #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dut_valid,
  output logic              dut_ready,
  output logic [ADDR_W-1:0] input_rd_addr,
  input  logic [DATA_W-1:0] input_rd_data,
  output logic [ADDR_W-1:0] weight_rd_addr,
  input  logic [DATA_W-1:0] weight_rd_data,
  output logic              mac_clear,
  output logic              mac_en,
  output logic              mac_last,
  input  logic [DATA_W-1:0] mac_result,
  output logic              result_wr_en,
  output logic [ADDR_W-1:0] result_wr_addr,
  output logic [DATA_W-1:0] result_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LATCH_DIM = 3'd1,
    S_COMPUTE   = 3'd2,
    S_DRAIN     = 3'd3,
    S_WRITE     = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [3:0]        DRAIN_LAST = 4'(MAC_LAT);

  state_t            state;
  logic [15:0]       m_dim;
  logic [15:0]       k_dim;
  logic [15:0]       n_dim;
  logic [15:0]       i_cnt;
  logic [15:0]       j_cnt;
  logic [15:0]       k_cnt;
  logic [3:0]        drain_cnt;
  // a_base = 1 + i*K, b_base = 1 + j, c_ptr = i*N + j, all modulo 2^ADDR_W.
  // The stepped pointers replace every multiply in the address arithmetic.
  logic [ADDR_W-1:0] a_base;
  logic [ADDR_W-1:0] b_base;
  logic [ADDR_W-1:0] c_ptr;

  // Only the low 32 bits of word 0 carry dimensions. The remaining read-data
  // bits are folded here so that they are visibly consumed.
  logic unused_rd_bits;
  assign unused_rd_bits = ^{input_rd_data, weight_rd_data};

  // Dimensions and strides reduce modulo 2^ADDR_W, so the address pointers
  // wrap exactly as the modular address map requires.
  function automatic logic [ADDR_W-1:0] to_addr(input logic [15:0] v);
    return ADDR_W'(v);
  endfunction

  logic in_compute;
  logic k_at_last;
  assign in_compute = (state == S_COMPUTE);
  assign k_at_last  = (k_cnt == k_dim - 16'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      dut_ready      <= 1'b1;
      input_rd_addr  <= '0;
      weight_rd_addr <= '0;
      mac_clear      <= 1'b0;
      mac_en         <= 1'b0;
      mac_last       <= 1'b0;
      result_wr_en   <= 1'b0;
      result_wr_addr <= '0;
      result_wr_data <= '0;
      m_dim          <= '0;
      k_dim          <= '0;
      n_dim          <= '0;
      i_cnt          <= '0;
      j_cnt          <= '0;
      k_cnt          <= '0;
      drain_cnt      <= '0;
      a_base         <= '0;
      b_base         <= '0;
      c_ptr          <= '0;
    end else begin
      // The MAC controls trail the address issue by one cycle, which lines
      // them up with the SRAM read data.
      mac_en    <= in_compute;
      mac_clear <= in_compute && (k_cnt == 16'd0);
      mac_last  <= in_compute && k_at_last;

      // The write strobe lasts exactly one cycle. The WRITE entry below
      // overrides these defaults.
      result_wr_en   <= 1'b0;
      result_wr_addr <= '0;
      result_wr_data <= '0;

      case (state)
        S_IDLE: begin
          if (dut_valid) begin
            state     <= S_LATCH_DIM;
            dut_ready <= 1'b0;
          end
        end

        S_LATCH_DIM: begin
          // Address 0 was presented while idle, so word 0 is on the buses now.
          m_dim     <= input_rd_data[31:16];
          k_dim     <= input_rd_data[15:0];
          n_dim     <= weight_rd_data[15:0];
          i_cnt     <= '0;
          j_cnt     <= '0;
          k_cnt     <= '0;
          c_ptr     <= '0;
          a_base    <= ADDR_ONE;
          b_base    <= ADDR_ONE;
          if ((input_rd_data[31:16] == 16'd0) || (input_rd_data[15:0] == 16'd0) ||
              (weight_rd_data[15:0] == 16'd0)) begin
            state     <= S_IDLE;
            dut_ready <= 1'b1;
          end else begin
            state          <= S_COMPUTE;
            input_rd_addr  <= ADDR_ONE;
            weight_rd_addr <= ADDR_ONE;
          end
        end

        S_COMPUTE: begin
          if (k_at_last) begin
            state          <= S_DRAIN;
            drain_cnt      <= '0;
            k_cnt          <= '0;
            input_rd_addr  <= '0;
            weight_rd_addr <= '0;
          end else begin
            k_cnt          <= k_cnt + 16'd1;
            input_rd_addr  <= input_rd_addr + ADDR_ONE;
            weight_rd_addr <= weight_rd_addr + to_addr(n_dim);
          end
        end

        S_DRAIN: begin
          // The final mac_en fires in the first DRAIN cycle. After MAC_LAT more
          // cycles mac_result is settled, and it is captured on entry to WRITE.
          if (drain_cnt == DRAIN_LAST) begin
            state          <= S_WRITE;
            result_wr_en   <= 1'b1;
            result_wr_addr <= c_ptr;
            result_wr_data <= mac_result;
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end

        S_WRITE: begin
          c_ptr <= c_ptr + ADDR_ONE;
          if (j_cnt == n_dim - 16'd1) begin
            j_cnt <= '0;
            if (i_cnt == m_dim - 16'd1) begin
              i_cnt     <= '0;
              state     <= S_IDLE;
              dut_ready <= 1'b1;
            end else begin
              i_cnt          <= i_cnt + 16'd1;
              a_base         <= a_base + to_addr(k_dim);
              b_base         <= ADDR_ONE;
              state          <= S_COMPUTE;
              input_rd_addr  <= a_base + to_addr(k_dim);
              weight_rd_addr <= ADDR_ONE;
            end
          end else begin
            j_cnt          <= j_cnt + 16'd1;
            b_base         <= b_base + ADDR_ONE;
            state          <= S_COMPUTE;
            input_rd_addr  <= a_base;
            weight_rd_addr <= b_base + ADDR_ONE;
          end
        end

        default: begin
          state     <= S_IDLE;
          dut_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
// ============================================================================
// Module   : tb_matmul_sequencer
// Purpose  : Bench for matmul_sequencer. Sparse SRAM and MAC models surround
//            the DUT. Expected C elements come from direct matrix arithmetic
//            and are queued at job issue; a write monitor pops and compares
//            them. Job latency, idle outputs, MAC control flags and
//            mid-job reset are also checked.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matmul_sequencer;

  localparam int AW      = 8;
  localparam int DW      = 32;
  localparam int MAC_LAT = 2;
  localparam int DEPTH   = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          dut_valid = 1'b0;
  logic          dut_ready;
  logic [AW-1:0] input_rd_addr;
  logic [DW-1:0] input_rd_data;
  logic [AW-1:0] weight_rd_addr;
  logic [DW-1:0] weight_rd_data;
  logic          mac_clear;
  logic          mac_en;
  logic          mac_last;
  logic [DW-1:0] mac_result;
  logic          result_wr_en;
  logic [AW-1:0] result_wr_addr;
  logic [DW-1:0] result_wr_data;

  matmul_sequencer #(.ADDR_W(AW), .DATA_W(DW), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .dut_valid(dut_valid), .dut_ready(dut_ready),
    .input_rd_addr(input_rd_addr), .input_rd_data(input_rd_data),
    .weight_rd_addr(weight_rd_addr), .weight_rd_data(weight_rd_data),
    .mac_clear(mac_clear), .mac_en(mac_en), .mac_last(mac_last),
    .mac_result(mac_result), .result_wr_en(result_wr_en),
    .result_wr_addr(result_wr_addr), .result_wr_data(result_wr_data)
  );

  always #5 clk = ~clk;

  // ---------------- environment models ----------------
  logic [DW-1:0] in_mem [DEPTH];
  logic [DW-1:0] wt_mem [DEPTH];

  always @(posedge clk) begin
    input_rd_data  <= in_mem[input_rd_addr];
    weight_rd_data <= wt_mem[weight_rd_addr];
  end

  // Accumulator followed by a delay line; the result is visible MAC_LAT cycles after mac_en.
  logic [DW-1:0] mac_pipe [MAC_LAT];
  always @(posedge clk) begin
    if (mac_en)
      mac_pipe[0] <= mac_clear ? input_rd_data * weight_rd_data
                               : mac_pipe[0] + input_rd_data * weight_rd_data;
    for (int p = 1; p < MAC_LAT; p++) mac_pipe[p] <= mac_pipe[p-1];
  end
  assign mac_result = mac_pipe[MAC_LAT-1];

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q [$];
  int  checks   = 0;
  int  failures = 0;
  int  cur_k    = 0;   // K of the running job, 0 when no MAC activity is expected
  int  op_idx   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Write monitor: every result write must match the next expected element.
  always @(negedge clk) begin
    if (result_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {24'd0, result_wr_addr, result_wr_data}, 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr_data", {24'd0, result_wr_addr, result_wr_data}, {24'd0, e.addr, e.data});
      end
    end
  end

  // Idle monitor: while ready, read addresses are zero and nothing is written or accumulated.
  always @(negedge clk) begin
    if (dut_ready === 1'b1)
      chk("idle_outputs", {32'd0, input_rd_addr, weight_rd_addr, result_wr_en, mac_en,
                           mac_clear, mac_last}, 64'd0);
  end

  // MAC flag monitor: clear marks the first operand pair, last marks pair K-1.
  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      op_idx = 0;
    end else if (mac_en === 1'b1) begin
      if (cur_k == 0) begin
        chk("unexpected_mac_en", 64'd1, 64'd0);
      end else begin
        chk("mac_flags", {62'd0, mac_clear, mac_last},
            {62'd0, (op_idx == 0), (op_idx == cur_k - 1)});
        op_idx = (op_idx == cur_k - 1) ? 0 : op_idx + 1;
      end
    end else if ((mac_clear | mac_last) === 1'b1) begin
      chk("mac_flags_without_en", {62'd0, mac_clear, mac_last}, 64'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Fills both memories, writes the dimension words and queues the expected results.
  task automatic setup_job(input int m, input int k, input int n);
    for (int a = 0; a < DEPTH; a++) begin
      in_mem[a] = $urandom;
      wt_mem[a] = $urandom;
    end
    in_mem[0] = {m[15:0], k[15:0]};
    wt_mem[0] = {16'($urandom), n[15:0]};
    for (int i = 0; i < m; i++) begin
      for (int j = 0; j < n; j++) begin
        logic [DW-1:0] sum;
        wr_t e;
        sum = '0;
        for (int kk = 0; kk < k; kk++)
          sum = sum + in_mem[(1 + i*k + kk) % DEPTH] * wt_mem[(1 + kk*n + j) % DEPTH];
        e.addr = AW'((i*n + j) % DEPTH);
        e.data = sum;
        exp_q.push_back(e);
      end
    end
    cur_k = (m == 0 || k == 0 || n == 0) ? 0 : k;
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (dut_ready !== 1'b1 && guard < 2000) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 2000) chk("wait_ready_timeout", 64'd0, 64'd1);
  endtask

  // Issues one job at a negedge, and checks the number of cycles the DUT stays busy.
  task automatic run_job(input int m, input int k, input int n, input bit hold);
    int busy;
    int exp_busy;
    wait_ready();
    setup_job(m, k, n);
    exp_busy = 1 + m*n*(k + MAC_LAT + 2);
    dut_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) dut_valid = 1'b0;
    busy = 0;
    while (dut_ready !== 1'b1 && busy < exp_busy + 64) begin
      busy++;
      @(negedge clk);
    end
    chk("busy_cycles", 64'(busy), 64'(exp_busy));
  endtask

  // Aborts a 2x2x2 job during its second DRAIN, then checks the reset values.
  task automatic run_reset_job();
    int lasts = 0;
    int guard = 0;
    wait_ready();
    setup_job(2, 2, 2);
    dut_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dut_valid = 1'b0;
    while (lasts < 2 && guard < 200) begin
      if (mac_last === 1'b1) lasts++;
      if (lasts < 2) @(negedge clk);
      guard++;
    end
    chk("reset_job_reached_drain", 64'(lasts), 64'd2);
    #1 reset_n = 1'b0;
    #1;
    chk("reset_ready", {63'd0, dut_ready}, 64'd1);
    chk("reset_outputs", {input_rd_addr, weight_rd_addr, mac_clear, mac_en, mac_last,
                          result_wr_en, result_wr_addr, 24'd0}, 64'd0);
    chk("reset_wr_data", {32'd0, result_wr_data}, 64'd0);
    exp_q.delete();
    cur_k = 0;
    @(posedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      in_mem[a] = '0;
      wt_mem[a] = '0;
    end
    for (int p = 0; p < MAC_LAT; p++) mac_pipe[p] = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {63'd0, dut_ready}, 64'd1);
    reset_n = 1'b1;
    @(negedge clk);

    run_job(1, 1, 1, 1'b0);          // 6 busy cycles, one write
    run_job(2, 3, 2, 1'b0);          // 29 busy cycles, four writes
    run_job(0, 4, 5, 1'b0);          // M=0: one busy cycle, nothing else
    run_job(3, 2, 0, 1'b0);          // N=0
    run_job(1, 1, 3, 1'b0);          // clear and last coincide
    run_reset_job();
    run_job(1, 1, 1, 1'b0);          // first job after reset
    run_job(1, 2, 2, 1'b1);          // dut_valid held through back-to-back jobs
    run_job(2, 1, 2, 1'b1);
    run_job(1, 3, 1, 1'b0);
    for (int r = 0; r < 6; r++)
      run_job($urandom_range(1, 3), $urandom_range(1, 5), $urandom_range(1, 3), 1'(r % 2));
    run_job(1, 260, 1, 1'b0);        // operand addresses wrap past 2^ADDR_W
    run_job(17, 1, 16, 1'b0);        // result addresses wrap past 2^ADDR_W

    repeat (5) @(negedge clk);
    chk("all_writes_seen", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001: Parameter ADDR_W, default 12, sets the SRAM address width.
REQ-002: Parameter DATA_W, default 32, sets the SRAM data width.
REQ-003: Parameter MAC_LAT, default 2, range 1..15, is the fixed MAC pipeline latency from the last mac_en to a valid mac_result.
REQ-004: The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005: clk  in  1  rising-edge clock.
REQ-006: reset_n  in  1  asynchronous active-low reset.
REQ-007: dut_valid  in  1  job request.
REQ-008: dut_ready  out  1  high = idle and able to accept a job.
REQ-009: input_rd_addr  out  ADDR_W  input SRAM (matrix A) read address.
REQ-010: input_rd_data  in  DATA_W  input SRAM read data, valid one cycle after its address.
REQ-011: weight_rd_addr  out  ADDR_W  weight SRAM (matrix B) read address.
REQ-012: weight_rd_data  in  DATA_W  weight SRAM read data, valid one cycle after its address.
REQ-013: mac_clear  out  1  restart accumulation with the current operands.
REQ-014: mac_en  out  1  operands on the read-data buses are valid this cycle.
REQ-015: mac_last  out  1  final operand pair of the current dot product.
REQ-016: mac_result  in  DATA_W  accumulator output from the datapath.
REQ-017: result_wr_en  out  1  result SRAM write strobe.
REQ-018: result_wr_addr  out  ADDR_W  result SRAM write address.
REQ-019: result_wr_data  out  DATA_W  result SRAM write data.

Function
REQ-020: Memory layout: input[0] = {M[31:16], K[15:0]}; weight[0] = {K'[31:16], N[15:0]}; weight[0][31:16] is ignored and K comes from input[0].
REQ-021: Element locations: A[i][k] at input address 1+i*K+k; B[k][j] at weight address 1+k*N+j; C[i][j] written to result address i*N+j; all addresses modulo 2^ADDR_W.
REQ-022: The FSM SHALL have states IDLE, LATCH_DIM, COMPUTE, DRAIN and WRITE; dut_ready SHALL equal 1 exactly in IDLE.
REQ-023: IDLE: both read addresses SHALL be 0; dut_valid=1 at a clock edge moves the FSM to LATCH_DIM.
REQ-024: dut_valid SHALL be ignored in every state other than IDLE.
REQ-025: LATCH_DIM (1 cycle): M, K and N SHALL be registered from the read data; if any of them is 0, go to IDLE with no writes; otherwise go to COMPUTE with i=j=k=0.
REQ-026: COMPUTE (K cycles): drive input_rd_addr=1+i*K+k and weight_rd_addr=1+k*N+j, with k incrementing each cycle; after issuing k=K-1 go to DRAIN.
REQ-027: mac_en SHALL be the one-cycle-delayed copy of "COMPUTE issued an address".
REQ-028: mac_clear SHALL accompany the mac_en of k=0; mac_last SHALL accompany the mac_en of k=K-1; for K=1 both are asserted in the same cycle.
REQ-029: DRAIN SHALL last 1+MAC_LAT cycles, then go to WRITE.
REQ-030: WRITE (1 cycle): result_wr_en=1, result_wr_addr=i*N+j, result_wr_data=mac_result.
REQ-031: After WRITE: j++ and return to COMPUTE; if j=N-1, wrap j to 0 and i++; if i=M-1 and j=N-1, go to IDLE.
REQ-032: Element order SHALL be row-major; each C address SHALL be written exactly once.
REQ-033: Address arithmetic SHALL be incremental (no multipliers).
REQ-034: Dimension or address overflow beyond 2^ADDR_W SHALL wrap modulo 2^ADDR_W and SHALL NOT hang the FSM.
REQ-035: Latency from the accepting edge to dut_ready=1 SHALL be exactly 1 + M*N*(K+MAC_LAT+2) cycles.
REQ-036: Outside COMPUTE, both read addresses SHALL be 0; outside WRITE, result_wr_en SHALL be 0.
REQ-037: mac_en, mac_clear and mac_last SHALL be 0 except as defined in REQ-027 and REQ-028.

Reset
REQ-038: Asserting reset_n=0 at any time, including mid-job, SHALL force IDLE, dut_ready=1 and all other outputs and counters to 0.
REQ-039: After reset_n deasserts, the first job SHALL be accepted on the first edge with dut_valid=1.
REQ-040: A partially written result SRAM is not cleaned up after reset.

Verification
REQ-041: M=K=N=1, MAC_LAT=2, dut_valid pulsed -> dut_ready low for 6 cycles; one write to result address 0 containing mac_result.
REQ-042: M=2, K=3, N=2 -> 4 writes at addresses 0,1,2,3; read address pairs for C[1][0] are (4,1), (5,3), (6,5); dut_ready returns after 1+4*7=29 cycles.
REQ-043: input[0]=0x0000_0004 (M=0) -> dut_ready low for exactly 1 cycle; no mac_en; no writes.
REQ-044: K=1, N=3, M=1 -> mac_clear and mac_last coincide on each of 3 mac_en pulses.
REQ-045: reset_n pulsed low during the second DRAIN of a 2x2x2 job -> all outputs 0 and dut_ready=1 immediately; a following 1x1x1 job completes with correct latency.
REQ-046: dut_valid held high through an entire job and back-to-back jobs -> a second job starts on the first IDLE edge; no write occurs while in IDLE.
